// File: rtl/reg_write_arbiter_if.sv
// Register-file write port shared by two writeback requesters.
// master = requesters / regfile side, slave = arbiter.
interface reg_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              p0_valid;
    logic              p0_ready;
    logic [ADDR_W-1:0] p0_rd;
    logic [DATA_W-1:0] p0_data;
    logic              p1_valid;
    logic              p1_ready;
    logic [ADDR_W-1:0] p1_rd;
    logic [DATA_W-1:0] p1_data;
    logic              RegWrite;
    logic [ADDR_W-1:0] Rd;
    logic [DATA_W-1:0] Write_data;
    logic              grant_id;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_rd;

    modport master (
        output p0_valid, p0_rd, p0_data,
        output p1_valid, p1_rd, p1_data,
        input  p0_ready, p1_ready,
        input  RegWrite, Rd, Write_data,
        input  grant_id, pend_valid, pend_rd
    );

    modport slave (
        input  p0_valid, p0_rd, p0_data,
        input  p1_valid, p1_rd, p1_data,
        output p0_ready, p1_ready,
        output RegWrite, Rd, Write_data,
        output grant_id, pend_valid, pend_rd
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-source register-file write arbiter with registered output stage.
// Optional port-1 starvation guard under `STARVE_GUARD_EN.
module reg_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    reg_write_arbiter_if.slave bus
);
    logic              force1;
    logic              conflict;
    logic              conf_q;
    logic              p1_win;
    logic              p0_rdy;
    logic              p1_rdy;
    logic              we_q;
    logic              gid_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] wd_q;

    // conf_q lets port 0 win right after a same-destination grant
    assign conflict = bus.p0_valid && bus.p1_valid
                   && (bus.p0_rd == bus.p1_rd)
                   && (bus.p0_rd != '0) && !conf_q;

`ifdef STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
    logic [CW-1:0] cnt;

    assign force1 = bus.p1_valid && (cnt == LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!bus.p1_valid || p1_rdy) begin
            cnt <= '0;
        end else if (cnt != LIM) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign force1 = 1'b0;
`endif

    assign p1_win = force1 || conflict;

    always_comb begin
        p0_rdy = 1'b0;
        p1_rdy = 1'b0;
        if (bus.p0_valid && !p1_win) begin
            p0_rdy = 1'b1;
        end else if (bus.p1_valid) begin
            p1_rdy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conf_q <= 1'b0;
            we_q   <= 1'b0;
            gid_q  <= 1'b0;
            rd_q   <= '0;
            wd_q   <= '0;
        end else begin
            conf_q <= conflict && p1_rdy;
            we_q   <= 1'b0;
            if (p0_rdy) begin
                we_q  <= bus.p0_rd != '0;
                gid_q <= 1'b0;
                rd_q  <= bus.p0_rd;
                wd_q  <= bus.p0_data;
            end else if (p1_rdy) begin
                we_q  <= bus.p1_rd != '0;
                gid_q <= 1'b1;
                rd_q  <= bus.p1_rd;
                wd_q  <= bus.p1_data;
            end
        end
    end

    assign bus.p0_ready   = p0_rdy;
    assign bus.p1_ready   = p1_rdy;
    assign bus.RegWrite   = we_q;
    assign bus.Rd         = rd_q;
    assign bus.Write_data = wd_q;
    assign bus.grant_id   = gid_q;
    assign bus.pend_valid = we_q;
    assign bus.pend_rd    = rd_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and randomized bench for reg_write_arbiter.
// Honours `STARVE_GUARD_EN the same way the design does.
module tb_reg_write_arbiter;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   passed = 0;

    reg_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_write_arbiter #(
        .DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set(input logic v0, input logic [4:0] r0,
                       input logic [31:0] d0, input logic v1,
                       input logic [4:0] r1, input logic [31:0] d1);
        bus.p0_valid = v0; bus.p0_rd = r0; bus.p0_data = d0;
        bus.p1_valid = v1; bus.p1_rd = r1; bus.p1_data = d1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".p0_ready"}, 32'(bus.p0_ready), 32'(r0));
        chk({tag, ".p1_ready"}, 32'(bus.p1_ready), 32'(r1));
    endtask

    task automatic wr(input string tag, input logic we, input logic [4:0] rd,
                      input logic [31:0] wd, input logic gid);
        chk({tag, ".RegWrite"}, 32'(bus.RegWrite), 32'(we));
        chk({tag, ".pend_valid"}, 32'(bus.pend_valid), 32'(we));
        if (we) begin
            chk({tag, ".Rd"}, 32'(bus.Rd), 32'(rd));
            chk({tag, ".pend_rd"}, 32'(bus.pend_rd), 32'(rd));
            chk({tag, ".Write_data"}, bus.Write_data, wd);
            chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(gid));
        end
    endtask

    // reference model state
    bit          conf_last;
    int          wait1;
    bit          e_we, e_gid;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    bit          pend0, pend1;
    logic [31:0] regs [32];

    initial begin
        set(0, 0, 0, 0, 0, 0);
        #2;
        chk("rst.RegWrite", 32'(bus.RegWrite), 0);
        chk("rst.Rd", 32'(bus.Rd), 0);
        chk("rst.Write_data", bus.Write_data, 0);
        chk("rst.grant_id", 32'(bus.grant_id), 0);
        chk("rst.pend_rd", 32'(bus.pend_rd), 0);
        tick();
        reset = 1'b1;
        tick();

        set(1, 5, 32'hDEADBEEF, 0, 0, 0);
        rdy("p0only", 1, 0);
        tick();
        wr("p0only", 1, 5, 32'hDEADBEEF, 0);

        set(1, 3, 32'h11, 1, 9, 32'h22);
        rdy("both", 1, 0);
        tick();
        wr("both.c1", 1, 3, 32'h11, 0);
        set(0, 0, 0, 1, 9, 32'h22);
        rdy("both.p1", 0, 1);
        tick();
        wr("both.c2", 1, 9, 32'h22, 1);

        set(1, 12, 32'hA, 1, 12, 32'hB);
        rdy("waw", 0, 1);
        tick();
        wr("waw.c1", 1, 12, 32'hB, 1);
        set(1, 12, 32'hA, 1, 12, 32'hC);
        rdy("waw.next", 1, 0);
        tick();
        wr("waw.c2", 1, 12, 32'hA, 0);
        set(0, 0, 0, 1, 12, 32'hC);
        rdy("waw.p1", 0, 1);
        tick();
        wr("waw.c3", 1, 12, 32'hC, 1);

        set(1, 0, 32'hFF, 0, 0, 0);
        rdy("x0", 1, 0);
        tick();
        wr("x0", 0, 0, 0, 0);

        set(0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 1; k <= LIM; k++) begin
            set(1, 5'(k), 32'(k), 1, 20, 32'h2020);
            rdy($sformatf("starve.w%0d", k), 1, 0);
            tick();
        end
        set(1, 5'd5, 32'h5, 1, 20, 32'h2020);
`ifdef STARVE_GUARD_EN
        rdy("starve.force", 0, 1);
        tick();
        wr("starve.force", 1, 20, 32'h2020, 1);
`else
        for (int k = 0; k < 4; k++) begin
            rdy($sformatf("starve.strict%0d", k), 1, 0);
            tick();
            set(1, 5'(6 + k), 32'(k), 1, 20, 32'h2020);
        end
`endif

        set(1, 7, 32'h77, 0, 0, 0);
        tick();
        wr("midrst.pre", 1, 7, 32'h77, 0);
        set(0, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        #1;
        chk("midrst.RegWrite", 32'(bus.RegWrite), 0);
        chk("midrst.Rd", 32'(bus.Rd), 0);
        chk("midrst.pend_valid", 32'(bus.pend_valid), 0);
        chk("midrst.pend_rd", 32'(bus.pend_rd), 0);
        chk("midrst.Write_data", bus.Write_data, 0);
        chk("midrst.grant_id", 32'(bus.grant_id), 0);
        tick();
        reset = 1'b1;

        conf_last = 0; wait1 = 0; e_we = 0;
        pend0 = 0; pend1 = 0;
        foreach (regs[i]) regs[i] = 0;
        for (int n = 0; n < 400; n++) begin
            bit same, starve, w1, w0;
            tick();
            chk("rnd.RegWrite", 32'(bus.RegWrite), 32'(e_we));
            if (e_we) begin
                chk("rnd.Rd", 32'(bus.Rd), 32'(e_rd));
                chk("rnd.Write_data", bus.Write_data, e_wd);
                chk("rnd.grant_id", 32'(bus.grant_id), 32'(e_gid));
                regs[e_rd] = e_wd;
            end
            if (!pend0) begin
                bus.p0_valid = $urandom_range(0, 9) < 7;
                bus.p0_rd    = 5'($urandom_range(0, 3));
                bus.p0_data  = $urandom;
            end
            if (!pend1) begin
                bus.p1_valid = $urandom_range(0, 1) == 1;
                bus.p1_rd    = 5'($urandom_range(0, 3));
                bus.p1_data  = $urandom;
            end
            #1;
            same = bus.p0_valid && bus.p1_valid && bus.p0_rd == bus.p1_rd
                && bus.p0_rd != 0 && !conf_last;
`ifdef STARVE_GUARD_EN
            starve = bus.p1_valid && wait1 >= LIM;
`else
            starve = 0;
`endif
            w1 = bus.p1_valid && (!bus.p0_valid || same || starve);
            w0 = bus.p0_valid && !w1;
            rdy("rnd", w0, w1);
            conf_last = same && w1;
            wait1 = (bus.p1_valid && !w1) ? ((wait1 < LIM) ? wait1 + 1 : LIM) : 0;
            pend0 = bus.p0_valid && !w0;
            pend1 = bus.p1_valid && !w1;
            e_we = 0;
            if (w0) begin
                e_we = bus.p0_rd != 0; e_rd = bus.p0_rd;
                e_wd = bus.p0_data; e_gid = 0;
            end else if (w1) begin
                e_we = bus.p1_rd != 0; e_rd = bus.p1_rd;
                e_wd = bus.p1_data; e_gid = 1;
            end
        end
        chk("rnd.r0", regs[0], 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single register-file write port (RegWrite/Rd/Write_data) between two writeback sources.
  - Port 0: the in-order pipeline WB stage.
  - Port 1: the multi-cycle unit (mul/div/load-miss return).
- Valid/ready handshake on each requester. Registered output stage drives the register file.
- Exports the in-flight destination so the hazard/forwarding logic can see the pending write.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- STARVE_LIMIT, 4, consecutive cycles port 1 may lose before it is forced to win (only used with STARVE_GUARD_EN)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- p0_valid  input  1  port 0 write request
- p0_ready  output  1  port 0 request accepted this cycle
- p0_rd  input  ADDR_W  port 0 destination register
- p0_data  input  DATA_W  port 0 write data
- p1_valid  input  1  port 1 write request
- p1_ready  output  1  port 1 request accepted this cycle
- p1_rd  input  ADDR_W  port 1 destination register
- p1_data  input  DATA_W  port 1 write data
- RegWrite  output  1  register-file write enable (registered)
- Rd  output  ADDR_W  register-file write index (registered)
- Write_data  output  DATA_W  register-file write data (registered)
- grant_id  output  1  source of the current output-stage write: 0 = port 0, 1 = port 1
- pend_valid  output  1  a write to a non-zero register is in the output stage
- pend_rd  output  ADDR_W  destination of that write

Behaviour:
- Reset (reset low, async): RegWrite, Rd, Write_data, grant_id, pend_valid, pend_rd = 0; starvation counter = 0. Takes effect mid-operation; any in-flight write is discarded.
- Handshake: transfer occurs when valid && ready in the same cycle. ready is combinational from valids and arbitration state. At most one of p0_ready / p1_ready is high per cycle.
- Requester rule: a requester holds rd/data stable while valid && !ready. It may not drop valid before acceptance.
- Arbitration, default: port 0 wins.
  - p0_ready = p0_valid && !force1.
  - p1_ready = p1_valid && (!p0_valid || force1).
- Same-destination conflict: p0_valid && p1_valid && p0_rd == p1_rd && p0_rd != 0 → port 1 wins this cycle (older instruction first, preserves WAW order). Port 0 wins the next cycle.
- Latency: one cycle. A transfer in cycle N → RegWrite=1, Rd, Write_data, grant_id valid in cycle N+1.
- No transfer in cycle N → RegWrite=0 in N+1. Rd and Write_data hold their previous values.
- x0 writes: a transfer with rd == 0 is accepted (ready=1) but RegWrite=0 and pend_valid=0 in N+1.
- pend_valid equals RegWrite; pend_rd equals Rd. The hazard unit treats these as the register-file write-through condition.
- Register file never stalls, so there is no back-pressure from the output side. Throughput is one write per cycle.

Optional Feature:
- Macro: STARVE_GUARD_EN.
- Defined:
  - Counter of consecutive cycles with p1_valid && !p1_ready. Saturates at STARVE_LIMIT.
  - force1 = (count == STARVE_LIMIT).
  - Counter clears on any port-1 transfer or when p1_valid is low.
- Undefined: force1 is tied 0, no counter exists, port 0 has strict priority (apart from the same-destination rule).

Test Plan:
- Reset low mid-write (RegWrite=1, Rd=7) → all outputs 0 immediately, before the next clk edge.
- p0_valid, rd=5, data=0xDEADBEEF, p1 idle → p0_ready=1. Next cycle RegWrite=1, Rd=5, Write_data=0xDEADBEEF, grant_id=0, pend_valid=1, pend_rd=5.
- Both valid, p0 rd=3 data=0x11, p1 rd=9 data=0x22 → cycle N+1 writes r3 (grant 0). Port 1 accepted at N+1, so N+2 writes r9 (grant 1).
- Both valid, same rd=12, p0 data=0xA, p1 data=0xB → r12=0xB written first (grant 1), then r12=0xA. Final register value 0xA.
- p0 valid with rd=0, data=0xFF → p0_ready=1. Next cycle RegWrite=0, pend_valid=0.
- STARVE_GUARD_EN, STARVE_LIMIT=4, p0 valid every cycle with distinct rd, p1 valid rd=20 → p1 waits exactly 4 cycles. Cycle 5: p1_ready=1, p0_ready=0. Next cycle Rd=20, grant_id=1. Without the macro, p1 never accepted while p0 stays valid.
